// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues req/gnt/rvalid memory requests, buffers responses
// in an in-order prefetch FIFO and presents the head to the IF-ID register.
module instr_fetch #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        id_ready_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_rdata_o,
  output logic [31:0] if_instr_addr_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [31:0] BOOT_PC = BOOT_ADDR & ~32'h3;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CNT_W:0] DEPTH_U  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0] DEPTH_M1 = (CNT_W + 1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [31:0]        resp_pc;
  logic               redir_pend;
  logic [31:0]        redir_addr_q;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   discard_cnt;
  logic [CNT_W-1:0]   fifo_count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [31:0]        fifo_data [FIFO_DEPTH];
  logic [31:0]        fifo_addr [FIFO_DEPTH];

  logic               grant;
  logic               drop;
  logic               push;
  logic               pop;
  logic [31:0]        target;
  logic [CNT_W-1:0]   outstanding_nxt;
  logic [CNT_W:0]     used;

  assign grant  = instr_req_o & instr_gnt_i;
  assign drop   = instr_rvalid_i & (discard_cnt != '0);
  // A response arriving in the redirect cycle is stale and never enters the FIFO.
  assign push   = instr_rvalid_i & (discard_cnt == '0) & ~redirect_i;
  assign pop    = if_valid_o & id_ready_i & ~redirect_i;
  assign target = redirect_addr_i & ~32'h3;
  assign outstanding_nxt = outstanding + CNT_W'(grant) - CNT_W'(instr_rvalid_i);
  assign used   = {1'b0, fifo_count} + {1'b0, outstanding};

  assign instr_addr_o     = fetch_pc;
  assign if_valid_o       = (fifo_count != '0);
  assign if_instr_rdata_o = if_valid_o ? fifo_data[rd_ptr] : NOP;
  assign if_instr_addr_o  = if_valid_o ? fifo_addr[rd_ptr] : 32'h0;

  // Request FSM: credit counts are the registered values, a same-cycle pop is not credited.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      instr_req_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state       <= REQ;
          instr_req_o <= 1'b1;
        end
        REQ: begin
          if (grant && (used >= DEPTH_M1)) begin
            state       <= FULL;
            instr_req_o <= 1'b0;
          end
        end
        FULL: begin
          if (used < DEPTH_U) begin
            state       <= REQ;
            instr_req_o <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          instr_req_o <= 1'b0;
        end
      endcase
    end
  end

  // Fetch PC, redirect bookkeeping and in-flight/discard accounting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc     <= BOOT_PC;
      resp_pc      <= BOOT_PC;
      redir_pend   <= 1'b0;
      redir_addr_q <= 32'h0;
      outstanding  <= '0;
      discard_cnt  <= '0;
    end else begin
      outstanding <= outstanding_nxt;

      if (grant) begin
        redir_pend <= 1'b0;
        if (redirect_i)      fetch_pc <= target;
        else if (redir_pend) fetch_pc <= redir_addr_q;
        else                 fetch_pc <= fetch_pc + 32'd4;
      end else if (redirect_i) begin
        // An ungranted request must hold its address; the target waits for the grant.
        if (instr_req_o) begin
          redir_pend   <= 1'b1;
          redir_addr_q <= target;
        end else begin
          fetch_pc <= target;
        end
      end

      if (redirect_i)
        discard_cnt <= outstanding_nxt;
      else
        discard_cnt <= discard_cnt - CNT_W'(drop) + CNT_W'(grant & redir_pend);

      if (redirect_i) resp_pc <= target;
      else if (push)  resp_pc <= resp_pc + 32'd4;
    end
  end

  // Prefetch FIFO control.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else if (redirect_i) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Prefetch FIFO storage.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= instr_rdata_i;
      fifo_addr[wr_ptr] <= resp_pc;
    end
  end

endmodule
